// File: rtl/ucie_sb_serializer.sv
// ucie_sb_serializer: UCIe sideband TX serializer.
// Takes one PKT_W-bit packet per valid/ready handshake, shifts it out LSB
// first on SBTX_DATA with a gated SBTX_CLK (1 UI = 2 clk cycles), then holds
// both pins low for 2*GAP_UI clk cycles before accepting the next packet.
// Optional feature macro: UCIE_SB_SER_PKT_CNT_EN adds a 16-bit wrapping
// count of fully sent packets on output pkt_cnt.
module ucie_sb_serializer #(
    parameter int unsigned PKT_W  = 64,
    parameter int unsigned GAP_UI = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PKT_W-1:0] pkt_data,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    output logic             SBTX_CLK,
    output logic             SBTX_DATA,
    output logic             busy
`ifdef UCIE_SB_SER_PKT_CNT_EN
    ,
    output logic [15:0]      pkt_cnt
`endif
);

    localparam int unsigned BIT_W = $clog2(PKT_W);
    localparam int unsigned GAP_W = $clog2(2 * GAP_UI + 1);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PKT_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(2 * GAP_UI - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    // Bit 0 of the packet goes straight to the pin; the rest wait here.
    logic [PKT_W-2:0] r_sr;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_phase;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_sbtx_clk;
    logic             r_sbtx_data;

    logic w_shift_done;
    logic w_gap_done;

    assign w_shift_done = (r_state == ST_SHIFT) && r_phase && (r_bit_cnt == LAST_BIT);
    assign w_gap_done   = (r_state == ST_GAP) && (r_gap_cnt == LAST_GAP);

    assign pkt_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_GAP);
    assign SBTX_CLK  = r_sbtx_clk;
    assign SBTX_DATA = r_sbtx_data;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (pkt_valid)    w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_shift_done) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_gap_done)   w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Shift datapath, UI phase and counters; pins are driven from flops only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_phase     <= 1'b0;
            r_gap_cnt   <= '0;
            r_sbtx_clk  <= 1'b0;
            r_sbtx_data <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        r_sr        <= pkt_data[PKT_W-1:1];
                        r_sbtx_data <= pkt_data[0];
                        r_sbtx_clk  <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_phase     <= 1'b0;
                        r_gap_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (!r_phase) begin
                        r_phase    <= 1'b1;
                        r_sbtx_clk <= 1'b1;
                    end else begin
                        r_phase    <= 1'b0;
                        r_sbtx_clk <= 1'b0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_sbtx_data <= 1'b0;
                            r_gap_cnt   <= '0;
                        end else begin
                            r_bit_cnt   <= r_bit_cnt + BIT_W'(1);
                            r_sbtx_data <= r_sr[0];
                            r_sr        <= r_sr >> 1;
                        end
                    end
                end
                ST_GAP: begin
                    r_sbtx_clk  <= 1'b0;
                    r_sbtx_data <= 1'b0;
                    r_gap_cnt   <= w_gap_done ? '0 : (r_gap_cnt + GAP_W'(1));
                end
                default: begin
                    r_sbtx_clk  <= 1'b0;
                    r_sbtx_data <= 1'b0;
                end
            endcase
        end
    end

`ifdef UCIE_SB_SER_PKT_CNT_EN
    logic [15:0] r_pkt_cnt;

    assign pkt_cnt = r_pkt_cnt;

    // Count packets whose gap completed; reset-aborted packets never get here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt <= 16'h0000;
        end else if (w_gap_done) begin
            r_pkt_cnt <= r_pkt_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ucie_sb_serializer.sv
// Bench for ucie_sb_serializer: per-cycle comparison against a timeline
// model (outputs as a function of cycles since acceptance), a table of
// single-packet vectors, hand-written corner sequences and random traffic.
module tb_ucie_sb_serializer;

    localparam int P   = 64;
    localparam int G   = 32;
    localparam int PER = 2 * P + 2 * G;

    logic          clk;
    logic          reset_n;
    logic [P-1:0]  pkt_data;
    logic          pkt_valid;
    logic          pkt_ready;
    logic          SBTX_CLK;
    logic          SBTX_DATA;
    logic          busy;
`ifdef UCIE_SB_SER_PKT_CNT_EN
    logic [15:0]   pkt_cnt;
`endif

    ucie_sb_serializer #(.PKT_W(P), .GAP_UI(G)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .SBTX_CLK  (SBTX_CLK),
        .SBTX_DATA (SBTX_DATA),
        .busy      (busy)
`ifdef UCIE_SB_SER_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: idle flag, cycle index k since the accepting edge.
    bit           m_idle = 1'b1;
    int           m_k    = 0;
    logic [P-1:0] m_pkt  = '0;
    logic [15:0]  m_cnt  = '0;
    int           t_acc  = 0;

    // Serial monitor.
    logic [P-1:0] rec;
    int           n_edges;
    int           first_edge;
    int           last_edge;
    int           first_ready;
    int           gap_lo;
    bit           seen_busy;
    logic         prev_clk = 1'b0;

    typedef struct {
        logic [P-1:0] data_in;
        logic [P-1:0] exp_rec;
        int           exp_edges;
        int           exp_first;
        int           exp_last;
        int           exp_ready;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic e_ready, e_busy, e_clk, e_data;
        if (m_idle) begin
            e_ready = 1'b1; e_busy = 1'b0; e_clk = 1'b0; e_data = 1'b0;
        end else if (m_k <= 2 * P) begin
            e_ready = 1'b0; e_busy = 1'b1;
            e_clk   = ((m_k % 2) == 0);
            e_data  = m_pkt[(m_k - 1) / 2];
        end else begin
            e_ready = 1'b0; e_busy = 1'b1; e_clk = 1'b0; e_data = 1'b0;
        end
        chk("pkt_ready", 64'(pkt_ready), 64'(e_ready));
        chk("busy",      64'(busy),      64'(e_busy));
        chk("SBTX_CLK",  64'(SBTX_CLK),  64'(e_clk));
        chk("SBTX_DATA", 64'(SBTX_DATA), 64'(e_data));
`ifdef UCIE_SB_SER_PKT_CNT_EN
        chk("pkt_cnt",   64'(pkt_cnt),   64'(m_cnt));
`endif
    endtask

    task automatic mon_clear();
        rec         = '0;
        n_edges     = 0;
        first_edge  = -1;
        last_edge   = -1;
        first_ready = -1;
        gap_lo      = 0;
        seen_busy   = 1'b0;
    endtask

    task automatic monitor();
        int off;
        off = cyc + 1 - t_acc;
        if (SBTX_CLK && !prev_clk) begin
            if (n_edges < P) rec[n_edges] = SBTX_DATA;
            if (n_edges == 0) first_edge = off;
            last_edge = off;
            n_edges++;
        end
        prev_clk = SBTX_CLK;
        if (!pkt_ready) seen_busy = 1'b1;
        if (pkt_ready && seen_busy && first_ready < 0) first_ready = off;
        if (off > 2 * P && off <= PER + 1 && busy && !SBTX_CLK && !SBTX_DATA) gap_lo++;
    endtask

    // One clock: drive inputs, advance the model at the edge, sample after it.
    task automatic tick(input logic v, input logic [P-1:0] d);
        pkt_valid = v;
        pkt_data  = d;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            m_idle = 1'b1;
            m_cnt  = '0;
        end else if (m_idle) begin
            if (v) begin
                m_idle = 1'b0;
                m_k    = 1;
                m_pkt  = d;
                t_acc  = cyc;
            end
        end else begin
            m_k++;
            if (m_k > PER) begin
                m_idle = 1'b1;
                m_cnt  = m_cnt + 16'd1;
            end
        end
        #1;
        check_outputs();
        monitor();
    endtask

    function automatic logic [P-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Send one packet and wait out its full shift + gap window.
    task automatic send_pkt(input logic [P-1:0] d);
        mon_clear();
        tick(1'b1, d);
        for (int i = 0; i < PER; i++) tick(1'b0, rnd64());
    endtask

    initial begin
        logic [P-1:0] a;

        vecs[0] = '{64'hA5A5_0000_FFFF_1234, 64'hA5A5_0000_FFFF_1234, 64, 2, 128, 193};
        vecs[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64, 2, 128, 193};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 2, 128, 193};
        vecs[3] = '{64'h5555_AAAA_3333_CCCC, 64'h5555_AAAA_3333_CCCC, 64, 2, 128, 193};
        vecs[4] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64, 2, 128, 193};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64, 2, 128, 193};

        // Reset held with valid asserted: nothing accepted, pins quiet.
        reset_n   = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        mon_clear();
        for (int i = 0; i < 5; i++) tick(1'b1, rnd64());
        chk("reset_no_edges", 64'(n_edges), 64'd0);
        reset_n = 1'b1;
        tick(1'b0, '0);

        // Table of single packets.
        for (int v = 0; v < 6; v++) begin
            send_pkt(vecs[v].data_in);
            chk("vec_recovered",  rec,                vecs[v].exp_rec);
            chk("vec_edges",      64'(n_edges),       64'(vecs[v].exp_edges));
            chk("vec_first_edge", 64'(first_edge),    64'(vecs[v].exp_first));
            chk("vec_last_edge",  64'(last_edge),     64'(vecs[v].exp_last));
            chk("vec_ready_back", 64'(first_ready),   64'(vecs[v].exp_ready));
            chk("vec_gap_cycles", 64'(gap_lo),        64'(2 * G));
        end

        // Back-to-back with valid held high: two packets queued.
        mon_clear();
        a = 64'h0123_4567_89AB_CDEF;
        tick(1'b1, a);
        for (int i = 0; i < PER; i++) tick(1'b1, a);
        chk("b2b_first_rec",   rec,              a);
        chk("b2b_gap_cycles",  64'(gap_lo),      64'(2 * G));
        chk("b2b_ready_back",  64'(first_ready), 64'd193);
        mon_clear();
        a = 64'hFEDC_BA98_7654_3210;
        tick(1'b1, a);
        for (int i = 0; i < PER; i++) tick(1'b0, '0);
        chk("b2b_second_rec",  rec,              a);
        chk("b2b_second_edges", 64'(n_edges),    64'd64);

        // Valid pulsed while shifting is ignored.
        mon_clear();
        a = 64'hA5A5_0000_FFFF_1234;
        tick(1'b1, a);
        for (int i = 1; i <= PER; i++) tick((i == 30 || i == 31 || i == 150), 64'h1);
        chk("busy_valid_rec",   rec,           a);
        chk("busy_valid_edges", 64'(n_edges),  64'd64);

        // Reset in the middle of bit 20: pins drop without waiting for a clock.
        mon_clear();
        tick(1'b1, rnd64());
        for (int i = 0; i < 40; i++) tick(1'b0, '0);
        chk("pre_rst_clk_low", 64'(SBTX_CLK), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        m_idle = 1'b1;
        m_cnt  = '0;
        chk("async_rst_clk",   64'(SBTX_CLK),  64'd0);
        chk("async_rst_data",  64'(SBTX_DATA), 64'd0);
        chk("async_rst_busy",  64'(busy),      64'd0);
        chk("async_rst_ready", 64'(pkt_ready), 64'd1);
        for (int i = 0; i < 4; i++) tick(1'b1, rnd64());
        reset_n = 1'b1;
        send_pkt(64'hDEAD_BEEF_0000_0001);
        chk("post_rst_rec",   rec,              64'hDEAD_BEEF_0000_0001);
        chk("post_rst_edges", 64'(n_edges),     64'd64);
        chk("post_rst_first", 64'(first_edge),  64'd2);
        chk("post_rst_ready", 64'(first_ready), 64'd193);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) tick(($urandom_range(0, 3) == 0), rnd64());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
